// File: rtl/shift_cnt_pkg.sv
// Shared definitions for the shift pattern counter family.
//
// Contents:
//   MODE_JOHNSON / MODE_RING : encodings of the runtime mode input
//   MAX_WIDTH                : widest counter the helper function supports
//   reset_pattern(mode, w)   : state-0 pattern for a mode, right-aligned in a
//                              MAX_WIDTH vector. Callers size-cast the result
//                              down to their own width.
package shift_cnt_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam int MAX_WIDTH = 64;

  // Johnson state 0 is all zeros; ring state 0 has only the MSB set.
  function automatic logic [MAX_WIDTH-1:0] reset_pattern(input logic mode, input int width);
    logic [MAX_WIDTH-1:0] pat;
    pat = '0;
    if (mode == MODE_RING) pat[width-1] = 1'b1;
    return pat;
  endfunction

endpackage

// File: rtl/shift_pattern_decode.sv
// Combinational legality check and state-index decode of a counter pattern.
//
// Parameters:
//   WIDTH  counter bits (>= 2)
// Ports:
//   pattern  in   WIDTH   pattern to classify
//   mode     in   1       MODE_JOHNSON or MODE_RING
//   legal    out  1       pattern is a reachable state in that mode
//   idx      out  IDX_W   state index of the pattern (0 when illegal)
module shift_pattern_decode
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] pattern,
  input  logic             mode,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  int pop_cnt;
  int trans_cnt;
  int set_pos;

  // Gather the ones count, the number of adjacent-bit transitions and the
  // position of the highest set bit (only meaningful for one-hot patterns).
  always_comb begin
    pop_cnt   = 0;
    trans_cnt = 0;
    set_pos   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pattern[i]) begin
        pop_cnt = pop_cnt + 1;
        set_pos = i;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (pattern[i] != pattern[i+1]) trans_cnt = trans_cnt + 1;
    end
  end

  // Johnson states are a single run of ones anchored at one end, so they
  // have at most one internal transition. In the first half of the cycle
  // the ones are anchored at the MSB and the index equals the ones count;
  // in the second half they drain towards the LSB and the index counts down
  // from 2*WIDTH.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    if (mode == MODE_JOHNSON) begin
      legal = (trans_cnt <= 1);
      if (pattern[WIDTH-1] || pop_cnt == 0) idx = IDX_W'(pop_cnt);
      else                                  idx = IDX_W'(2 * WIDTH - pop_cnt);
    end else begin
      legal = (pop_cnt == 1);
      idx   = IDX_W'(WIDTH - 1 - set_pos);
    end
    if (!legal) idx = '0;
  end

endmodule

// File: rtl/shift_pattern_counter.sv
// Parametrised Johnson / one-hot ring shift counter with enable, direction,
// parallel load, decoded state index, wrap pulse and illegal-state recovery.
//
// Parameters:
//   WIDTH  counter bits (>= 2)
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset
//   mode      in   1      0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
//   en        in   1      advance one state
//   dir       in   1      0 = forward (index +1), 1 = reverse (index -1)
//   load      in   1      parallel load request
//   load_val  in   WIDTH  value to load, must be legal for the mode input
//   count     out  WIDTH  registered counter pattern
//   idx       out  IDX_W  registered state index of count
//   wrap      out  1      pulse: an advance landed on state 0
//   err       out  1      pulse: illegal load rejected or illegal state fixed
module shift_pattern_counter
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] step_pat;
  logic             step_legal;
  logic [IDX_W-1:0] step_idx;
  logic             load_legal;
  logic [IDX_W-1:0] load_idx;

  // One step of the current pattern in the latched mode and requested
  // direction. Johnson feeds back the inverted end bit, ring just rotates.
  always_comb begin
    step_pat = count_q;
    case ({mode_q, dir})
      {MODE_JOHNSON, 1'b0}: step_pat = {~count_q[0], count_q[WIDTH-1:1]};
      {MODE_JOHNSON, 1'b1}: step_pat = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      {MODE_RING,    1'b0}: step_pat = {count_q[0], count_q[WIDTH-1:1]};
      default:              step_pat = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    endcase
  end

  // Load values are judged against the mode input, since a legal load also
  // adopts that mode.
  shift_pattern_decode #(.WIDTH(WIDTH)) u_load_decode (
    .pattern (load_val),
    .mode    (mode),
    .legal   (load_legal),
    .idx     (load_idx)
  );

  // The step is a bijection whose only orbit over legal patterns is the
  // counting cycle itself, so the stepped pattern is legal exactly when the
  // current one is. One decoder therefore gives both the advance index and
  // the health check of count_q.
  shift_pattern_decode #(.WIDTH(WIDTH)) u_step_decode (
    .pattern (step_pat),
    .mode    (mode_q),
    .legal   (step_legal),
    .idx     (step_idx)
  );

  // Next-state selection in priority order: load, mode change, illegal
  // state correction, advance, hold. Reset is applied in the register.
  always_comb begin
    count_d = count_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_legal) begin
        count_d = load_val;
        idx_d   = load_idx;
        mode_d  = mode;
      end else begin
        err_d = 1'b1;
      end
    end else if (mode != mode_q) begin
      count_d = WIDTH'(reset_pattern(mode, WIDTH));
      idx_d   = '0;
      mode_d  = mode;
    end else if (!step_legal) begin
      count_d = WIDTH'(reset_pattern(mode_q, WIDTH));
      idx_d   = '0;
      err_d   = 1'b1;
    end else if (en) begin
      count_d = step_pat;
      idx_d   = step_idx;
      wrap_d  = (step_idx == '0);
    end
  end

  // Output and mode registers; reset picks the state-0 pattern of the mode
  // input so the counter starts in whichever mode is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= WIDTH'(reset_pattern(mode, WIDTH));
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= mode;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

  assign count = count_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_shift_pattern_counter.sv
// Self-checking bench for shift_pattern_counter at WIDTH=4.
// A table of directed single-edge vectors covers counting, wrap in both
// directions, loads, mode changes and holds; hand-written sequences cover
// reset priority and recovery from forced illegal states.
module tb_shift_pattern_counter;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [2:0] idx;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       mode;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic [2:0] exp_idx;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  shift_pattern_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .idx      (idx),
    .wrap     (wrap),
    .err      (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends one single-edge vector to the table.
  task automatic addVec(input string n, input logic r, input logic m, input logic e,
                        input logic d, input logic l, input logic [3:0] lv,
                        input logic [3:0] ec, input logic [2:0] ei,
                        input logic ew, input logic ee);
    vec_t v;
    v.name = n; v.rst = r; v.mode = m; v.en = e; v.dir = d; v.load = l;
    v.load_val = lv; v.exp_count = ec; v.exp_idx = ei; v.exp_wrap = ew; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Drives inputs on the falling edge, then waits past the next rising edge.
  task automatic applyStimulus(input logic r, input logic m, input logic e,
                               input logic d, input logic l, input logic [3:0] lv);
    @(negedge clk);
    reset = r; mode = m; en = e; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Compares every registered output with its expected value.
  task automatic checkOutput(input string n, input logic [3:0] ec, input logic [2:0] ei,
                             input logic ew, input logic ee);
    checks++;
    if (count !== ec) begin
      errors++;
      $display("[TB] FAIL %s count: got %b expected %b", n, count, ec);
    end
    checks++;
    if (idx !== ei) begin
      errors++;
      $display("[TB] FAIL %s idx: got %0d expected %0d", n, idx, ei);
    end
    checks++;
    if (wrap !== ew) begin
      errors++;
      $display("[TB] FAIL %s wrap: got %b expected %b", n, wrap, ew);
    end
    checks++;
    if (err !== ee) begin
      errors++;
      $display("[TB] FAIL %s err: got %b expected %b", n, err, ee);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;

    //        name          rst m  en d  ld load_val  count    idx wrap err
    // Johnson forward through a full cycle
    addVec("j_reset",     1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    addVec("j_fwd1",      0, 0, 1, 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
    addVec("j_fwd2",      0, 0, 1, 0, 0, 4'b0000, 4'b1100, 2, 0, 0);
    addVec("j_fwd3",      0, 0, 1, 0, 0, 4'b0000, 4'b1110, 3, 0, 0);
    addVec("j_fwd4",      0, 0, 1, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
    addVec("j_fwd5",      0, 0, 1, 0, 0, 4'b0000, 4'b0111, 5, 0, 0);
    addVec("j_fwd6",      0, 0, 1, 0, 0, 4'b0000, 4'b0011, 6, 0, 0);
    addVec("j_fwd7",      0, 0, 1, 0, 0, 4'b0000, 4'b0001, 7, 0, 0);
    addVec("j_fwd_wrap",  0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    // Johnson reverse through a full cycle
    addVec("j_rev7",      0, 0, 1, 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
    addVec("j_rev6",      0, 0, 1, 1, 0, 4'b0000, 4'b0011, 6, 0, 0);
    addVec("j_rev5",      0, 0, 1, 1, 0, 4'b0000, 4'b0111, 5, 0, 0);
    addVec("j_rev4",      0, 0, 1, 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
    addVec("j_rev3",      0, 0, 1, 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
    addVec("j_rev2",      0, 0, 1, 1, 0, 4'b0000, 4'b1100, 2, 0, 0);
    addVec("j_rev1",      0, 0, 1, 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
    addVec("j_rev_wrap",  0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    addVec("j_hold",      0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Ring mode from reset
    addVec("r_reset",     1, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 0);
    addVec("r_fwd1",      0, 1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
    addVec("r_fwd2",      0, 1, 1, 0, 0, 4'b0000, 4'b0010, 2, 0, 0);
    addVec("r_fwd3",      0, 1, 1, 0, 0, 4'b0000, 4'b0001, 3, 0, 0);
    addVec("r_fwd_wrap",  0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 1, 0);
    addVec("r_rev3",      0, 1, 1, 1, 0, 4'b0000, 4'b0001, 3, 0, 0);
    addVec("r_rev2",      0, 1, 1, 1, 0, 4'b0000, 4'b0010, 2, 0, 0);
    addVec("r_rev1",      0, 1, 1, 1, 0, 4'b0000, 4'b0100, 1, 0, 0);
    addVec("r_rev_wrap",  0, 1, 1, 1, 0, 4'b0000, 4'b1000, 0, 1, 0);
    addVec("r_load_bad",  0, 1, 1, 0, 1, 4'b0110, 4'b1000, 0, 0, 1);
    addVec("r_load_ok",   0, 1, 1, 0, 1, 4'b0010, 4'b0010, 2, 0, 0);
    // Back to Johnson, then loads
    addVec("mode_to_j",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    addVec("j_load_0111", 0, 0, 0, 0, 1, 4'b0111, 4'b0111, 5, 0, 0);
    addVec("j_load_0101", 0, 0, 0, 0, 1, 4'b0101, 4'b0111, 5, 0, 1);
    addVec("j_err_clear", 0, 0, 0, 0, 0, 4'b0000, 4'b0111, 5, 0, 0);
    addVec("j_load_en",   0, 0, 1, 0, 1, 4'b0011, 4'b0011, 6, 0, 0);
    addVec("j_load_1111", 0, 0, 1, 1, 1, 4'b1111, 4'b1111, 4, 0, 0);
    // Mode change mid-count overrides en
    addVec("j_load_1110", 0, 0, 0, 0, 1, 4'b1110, 4'b1110, 3, 0, 0);
    addVec("mode_to_r",   0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, 0);
    addVec("r_after_chg", 0, 1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
    addVec("r_hold",      0, 1, 0, 1, 0, 4'b0000, 4'b0100, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].en, vecs[i].dir,
                    vecs[i].load, vecs[i].load_val);
      checkOutput(vecs[i].name, vecs[i].exp_count, vecs[i].exp_idx,
                  vecs[i].exp_wrap, vecs[i].exp_err);
    end

    // Reset beats load and en
    applyStimulus(1, 0, 1, 0, 1, 4'b0111);
    checkOutput("rst_prio", 4'b0000, 0, 0, 0);

    // Forced illegal Johnson pattern with en low is corrected with err
    @(negedge clk);
    reset = 0; mode = 0; en = 0; dir = 0; load = 0; load_val = 4'b0000;
    force dut.count_q = 4'b1010;
    #1;
    release dut.count_q;
    @(posedge clk);
    #1;
    checkOutput("j_fix_hold", 4'b0000, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000);
    checkOutput("j_fix_clear", 4'b0000, 0, 0, 0);

    // Correction also outranks an advance request
    applyStimulus(0, 0, 1, 0, 0, 4'b0000);
    checkOutput("j_pre_force", 4'b1000, 1, 0, 0);
    @(negedge clk);
    force dut.count_q = 4'b0101;
    #1;
    release dut.count_q;
    @(posedge clk);
    #1;
    checkOutput("j_fix_en", 4'b0000, 0, 0, 1);

    // Ring mode: an all-zero pattern recovers to the ring reset pattern
    applyStimulus(0, 1, 0, 0, 0, 4'b0000);
    checkOutput("to_ring", 4'b1000, 0, 0, 0);
    @(negedge clk);
    force dut.count_q = 4'b0000;
    #1;
    release dut.count_q;
    @(posedge clk);
    #1;
    checkOutput("r_fix_zero", 4'b1000, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000);
    checkOutput("r_after_fix", 4'b0100, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
